// File: rtl/dfp_line_memory_if.sv
// Downward-facing port bundle between the cache (master) and a line memory (slave).
// Carries the whole-line request/response handshake plus the responder status flags.
interface dfp_line_memory_if;
  logic [31:0]  dfp_addr;
  logic         dfp_read;
  logic         dfp_write;
  logic [255:0] dfp_wdata;
  logic [255:0] dfp_rdata;
  logic         dfp_resp;
  logic         busy;
  logic         proto_err;

  modport master (
    output dfp_addr, dfp_read, dfp_write, dfp_wdata,
    input  dfp_rdata, dfp_resp, busy, proto_err
  );

  modport slave (
    input  dfp_addr, dfp_read, dfp_write, dfp_wdata,
    output dfp_rdata, dfp_resp, busy, proto_err
  );
endinterface

// File: rtl/dfp_line_memory.sv
// Fixed-latency 256-bit line store standing in for main memory below the cache.
// One transaction at a time; the response is a registered single-cycle pulse.
module dfp_line_memory #(
  parameter  int unsigned DEPTH    = 64,
  parameter  int unsigned LATENCY  = 4,
  localparam int unsigned IDX_BITS = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  dfp_line_memory_if.slave   dfp
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  localparam int unsigned     CNT_W    = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((LATENCY > 1) ? (LATENCY - 2) : 0);

  state_e               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 op_write_q;
  logic [IDX_BITS-1:0]  idx_q;
  logic [255:0]         wdata_q;
  logic                 resp_q;
  logic                 busy_q;
  logic                 err_q;
  logic [255:0]         rdata_q;
  logic [DEPTH-1:0]     valid_q;
  logic [255:0]         line_q [DEPTH];

  logic                 req;
  logic                 accept;
  logic                 drop;
  logic                 flip;
  logic                 finish_d;
  logic                 fin_write_d;
  logic [IDX_BITS-1:0]  req_idx;
  logic [IDX_BITS-1:0]  fin_idx_d;
  logic [255:0]         fin_wdata_d;
  logic [255:0]         rd_line_d;

  // Address bits outside the line index are deliberately ignored (aliasing).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{dfp.dfp_addr[31:5+IDX_BITS], dfp.dfp_addr[4:0]};

  assign req     = dfp.dfp_read | dfp.dfp_write;
  assign req_idx = dfp.dfp_addr[5 +: IDX_BITS];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    accept      = (state_q == IDLE) && req;
    drop        = (state_q == BUSY) && !req;
    flip        = (state_q == BUSY) && req && (op_write_q != dfp.dfp_write);
    finish_d    = 1'b0;
    fin_write_d = op_write_q;
    fin_idx_d   = idx_q;
    fin_wdata_d = wdata_q;
    if (LATENCY == 1) begin
      // Zero-length BUSY: the accepting edge is also the completing edge.
      finish_d    = accept;
      fin_write_d = dfp.dfp_write;
      fin_idx_d   = req_idx;
      fin_wdata_d = dfp.dfp_wdata;
    end else begin
      finish_d = (state_q == BUSY) && req && (cnt_q == CNT_LAST);
    end
    rd_line_d = valid_q[fin_idx_d] ? line_q[fin_idx_d] : '0;
  end

  // NOTE: line storage has no reset; the cleared valid bits make stale lines read as zero.
  always_ff @(posedge clk) begin
    if (finish_d && fin_write_d && !rst) begin
      line_q[fin_idx_d] <= fin_wdata_d;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_write_q <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      resp_q     <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      valid_q    <= '0;
    end else begin
      resp_q  <= 1'b0;
      rdata_q <= '0;
      if (finish_d) begin
        resp_q  <= 1'b1;
        rdata_q <= fin_write_d ? '0 : rd_line_d;
        if (fin_write_d) valid_q[fin_idx_d] <= 1'b1;
      end
      if (flip) err_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (accept) begin
            op_write_q <= dfp.dfp_write;
            idx_q      <= req_idx;
            wdata_q    <= dfp.dfp_wdata;
            busy_q     <= 1'b1;
            cnt_q      <= '0;
            if (dfp.dfp_read && dfp.dfp_write) err_q <= 1'b1;
            state_q    <= (LATENCY == 1) ? RESP : BUSY;
          end
        end
        BUSY: begin
          if (drop) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
          end else if (finish_d) begin
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RESP: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign dfp.dfp_resp  = resp_q;
  assign dfp.dfp_rdata = rdata_q;
  assign dfp.busy      = busy_q;
  assign dfp.proto_err = err_q;

endmodule
